run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Sequences the `computer` core's `cpu` from a small command interface: reset sequencing, run, halt, N-cycle single-step and restart.
- Produces a CPU clock-enable and the CPU reset.
- Freezes the CPU combinationally on `cpu_stop` (EBREAK) or a nonzero `cpu_error`, and masks spurious errors during reset.
- Sits beside `computer`. The top level forms `cpu_clk = clk | !cpu_clk_en`.

Parameters:
- CYCLE_W, 32, width of the enabled-tick counter.
- RESET_CYCLES, 2, number of `clk` cycles `cpu_reset` is held (min 1).
- AUTO_RUN, 0, 1 = enter RUNNING after reset sequence; 0 = enter HALTED.
- TIMEOUT_CYCLES, 1000000, watchdog limit (only with RUN_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state and enters RESETTING.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at posedge.
- cmd_op  input  2  0=RUN, 1=HALT, 2=STEP, 3=RESTART.
- step_count  input  16  number of ticks for STEP; 0 is treated as 1.
- cmd_err  output  1  one-cycle pulse: accepted command illegal in the current state.
- cpu_stop  input  1  EBREAK indication from cpu.
- cpu_error  input  CpuError  packed error struct from cpu; any nonzero bit = error.
- cpu_reset  output  1  reset to computer.
- cpu_clk_en  output  1  1 = the CPU receives this clk edge.
- state  output  3  0=RESETTING, 1=HALTED, 2=RUNNING, 3=STEPPING, 4=FAULT.
- halt_reason  output  3  0=NONE, 1=USER, 2=EBREAK, 3=STEP_DONE, 4=ERROR, 5=TIMEOUT.
- cycle_count  output  CYCLE_W  enabled CPU ticks since the last reset sequence completed.

Behaviour:
- **Async reset values:**
  - state=RESETTING, cpu_reset=1, halt_reason=NONE, cycle_count=0.
  - cmd_err=0, remaining=0, reset counter=0.
- **Masked errors (err_m):** err_m = (cpu_error != 0) & !cpu_reset & !mask. Register `mask` is 1 during RESETTING and for the first cycle after leaving it.
- **cpu_clk_en:**
  - Combinational: 1 in RESETTING.
  - In RUNNING/STEPPING: 1 only if !cpu_stop & !err_m.
  - 0 in HALTED and FAULT.
  - No CPU edge ever occurs in a cycle where stop/error is visible.
- **RESETTING:**
  - cpu_reset=1, cmd_ready=0.
  - After RESET_CYCLES posedges, cpu_reset drops.
  - Next state is RUNNING if AUTO_RUN else HALTED; halt_reason=NONE; cycle_count=0.
- **HALTED:**
  - cmd_ready=1.
  - RUN -> RUNNING.
  - STEP -> STEPPING, remaining=max(step_count,1).
  - RESTART -> RESETTING.
  - HALT -> stays, no error.
- **RUNNING:**
  - HALT -> HALTED/USER.
  - RESTART -> RESETTING.
  - RUN or STEP -> cmd_err pulse, no state change.
- **STEPPING:**
  - Each enabled tick decrements remaining.
  - A tick with remaining==1 -> HALTED/STEP_DONE.
  - HALT and RESTART behave as in RUNNING; RUN or STEP -> cmd_err.
- **FAULT:**
  - Only RESTART is legal; any other command -> cmd_err.
  - cpu_clk_en=0.
- **Stop and error events (RUNNING/STEPPING):**
  - err_m -> FAULT/ERROR.
  - Else cpu_stop -> HALTED/EBREAK.
- **Event priority in one cycle:** RESTART cmd > err_m > cpu_stop > STEP_DONE > HALT cmd.
  - A command overridden by an event is still consumed, with no cmd_err.
- **cycle_count:**
  - Increments on each posedge with cpu_clk_en=1 outside RESETTING.
  - Wraps modulo 2^CYCLE_W.
- **Register updates:** halt_reason is registered and holds until the next transition into RUNNING/STEPPING, which sets it to NONE.
- **Reset mid-operation:** asserting reset at any point forces RESETTING immediately (async); any in-flight command is dropped.

Optional Feature:
- Macro: RUN_TIMEOUT_EN.
- **When defined:**
  - A watchdog counter clears on entering RUNNING and counts enabled ticks while RUNNING.
  - On reaching TIMEOUT_CYCLES -> FAULT/TIMEOUT.
  - Priority is just below err_m.
  - STEPPING is not watched.
- **When undefined:**
  - No watchdog logic exists; TIMEOUT_CYCLES is unused.
  - Reason 5 is never produced.

Test Plan:
- **Reset sequence:** Reset 3 cycles, AUTO_RUN=0, cpu_error=2'b11 during reset -> cpu_reset high for 2 cycles after reset release, no FAULT, state=HALTED, cycle_count=0.
- **Step:**
  - STEP with step_count=5 -> exactly 5 cpu_clk_en pulses, state=HALTED, halt_reason=STEP_DONE, cycle_count=5.
  - STEP with step_count=0 -> 1 pulse.
- **EBREAK:** RUN, then cpu_stop raised on the 7th tick -> cpu_clk_en=0 in that same cycle, state=HALTED/EBREAK, cycle_count=6.
- **Error priority:** cpu_error nonzero and cpu_stop together while RUNNING -> FAULT/ERROR. RUN in FAULT -> cmd_err pulse. RESTART -> RESETTING, then HALTED with halt_reason=NONE.
- **Illegal command and user halt:** RUN issued while RUNNING -> cmd_err for 1 cycle, stays RUNNING. HALT -> HALTED/USER.
- **Watchdog:** RUN_TIMEOUT_EN, TIMEOUT_CYCLES=20, RUN with no stop -> FAULT/TIMEOUT after 20 enabled ticks, cycle_count=20.

Source files
------------

// File: rtl/run_controller.sv
// run_controller: reset/run/halt/step/restart sequencer for the cpu; `define RUN_TIMEOUT_EN adds a RUNNING watchdog.
// Commands act on the next clk edge, stop/error gate cpu_clk_en combinationally; cmd_ready_o is low only while RESETTING.
package run_controller_pkg;
   typedef struct packed {
      logic bus_fault;
      logic illegal_insn;
   } cpu_error_t;
endpackage

module run_controller
   import run_controller_pkg::*;
#(
   parameter int CYCLE_W        = 32,
   parameter int RESET_CYCLES   = 2,
   parameter int AUTO_RUN       = 0,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_op_i,
   input  logic [15:0]        step_count_i,
   output logic               cmd_err_o,
   input  logic               cpu_stop_i,
   input  cpu_error_t         cpu_error_i,
   output logic               cpu_reset_o,
   output logic               cpu_clk_en_o,
   output logic [2:0]         state_o,
   output logic [2:0]         halt_reason_o,
   output logic [CYCLE_W-1:0] cycle_count_o
);

   typedef enum logic [2:0] {
      S_RESETTING = 3'd0,
      S_HALTED    = 3'd1,
      S_RUNNING   = 3'd2,
      S_STEPPING  = 3'd3,
      S_FAULT     = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      R_NONE      = 3'd0,
      R_USER      = 3'd1,
      R_EBREAK    = 3'd2,
      R_STEP_DONE = 3'd3,
      R_ERROR     = 3'd4,
      R_TIMEOUT   = 3'd5
   } reason_e;

   localparam logic [1:0] OP_RUN     = 2'd0;
   localparam logic [1:0] OP_HALT    = 2'd1;
   localparam logic [1:0] OP_STEP    = 2'd2;
   localparam logic [1:0] OP_RESTART = 2'd3;

   localparam int             RCW     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);

   state_e               state_q, state_d;
   reason_e              reason_q, reason_d;
   logic [CYCLE_W-1:0]   cycle_q, cycle_d;
   logic [15:0]          remaining_q, remaining_d;
   logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
   logic                 cmd_err_q, cmd_err_d;
   logic                 mask_q;
   logic                 err_m;
   logic                 tick;
   logic                 cmd_fire;
   logic                 timeout;

   assign cpu_reset_o   = (state_q == S_RESETTING);
   assign cmd_ready_o   = (state_q != S_RESETTING);
   assign cmd_err_o     = cmd_err_q;
   assign state_o       = state_q;
   assign halt_reason_o = reason_q;
   assign cycle_count_o = cycle_q;

   // Errors are ignored while the cpu is in reset and for one cycle after it leaves.
   assign err_m    = (|cpu_error_i) & ~cpu_reset_o & ~mask_q;
   assign cmd_fire = cmd_valid_i & cmd_ready_o;
   assign tick     = cpu_clk_en_o & (state_q != S_RESETTING);

   always_comb begin
      cpu_clk_en_o = 1'b0;
      case (state_q)
         S_RESETTING:          cpu_clk_en_o = 1'b1;
         S_RUNNING, S_STEPPING: cpu_clk_en_o = ~cpu_stop_i & ~err_m;
         default:              cpu_clk_en_o = 1'b0;
      endcase
   end

`ifdef RUN_TIMEOUT_EN
   logic [31:0] wdog_q, wdog_d;

   // The watchdog fires on the tick that completes TIMEOUT_CYCLES, so no extra tick leaks through.
   assign timeout = (state_q == S_RUNNING) && tick && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wdog_d = wdog_q;
      if (state_d == S_RUNNING && state_q != S_RUNNING)
         wdog_d = '0;
      else if (state_q == S_RUNNING && tick)
         wdog_d = wdog_q + 32'd1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) wdog_q <= '0;
      else         wdog_q <= wdog_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      reason_d    = reason_q;
      remaining_d = remaining_q;
      rst_cnt_d   = rst_cnt_q;
      cmd_err_d   = 1'b0;
      cycle_d     = tick ? cycle_q + CYCLE_W'(1) : cycle_q;

      case (state_q)
         S_RESETTING: begin
            if (rst_cnt_q == RC_LAST) begin
               state_d   = (AUTO_RUN != 0) ? S_RUNNING : S_HALTED;
               reason_d  = R_NONE;
               cycle_d   = '0;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RCW'(1);
            end
         end
         S_HALTED: begin
            if (cmd_fire) begin
               case (cmd_op_i)
                  OP_RUN: begin
                     state_d  = S_RUNNING;
                     reason_d = R_NONE;
                  end
                  OP_STEP: begin
                     state_d     = S_STEPPING;
                     reason_d    = R_NONE;
                     remaining_d = (step_count_i == 16'd0) ? 16'd1 : step_count_i;
                  end
                  OP_RESTART: state_d = S_RESETTING;
                  default: ;
               endcase
            end
         end
         S_RUNNING, S_STEPPING: begin
            // Overridden commands are consumed silently; only a surviving RUN/STEP is an error.
            if (cmd_fire && cmd_op_i == OP_RESTART) begin
               state_d = S_RESETTING;
            end else if (err_m) begin
               state_d  = S_FAULT;
               reason_d = R_ERROR;
            end else if (timeout) begin
               state_d  = S_FAULT;
               reason_d = R_TIMEOUT;
            end else if (cpu_stop_i) begin
               state_d  = S_HALTED;
               reason_d = R_EBREAK;
            end else if (state_q == S_STEPPING && remaining_q == 16'd1) begin
               state_d  = S_HALTED;
               reason_d = R_STEP_DONE;
            end else if (cmd_fire && cmd_op_i == OP_HALT) begin
               state_d  = S_HALTED;
               reason_d = R_USER;
            end else if (cmd_fire) begin
               cmd_err_d = 1'b1;
            end
            if (state_q == S_STEPPING && tick)
               remaining_d = remaining_q - 16'd1;
         end
         S_FAULT: begin
            if (cmd_fire) begin
               if (cmd_op_i == OP_RESTART) state_d = S_RESETTING;
               else                        cmd_err_d = 1'b1;
            end
         end
         default: state_d = S_RESETTING;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_RESETTING;
         reason_q    <= R_NONE;
         cycle_q     <= '0;
         remaining_q <= '0;
         rst_cnt_q   <= '0;
         cmd_err_q   <= 1'b0;
         mask_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         reason_q    <= reason_d;
         cycle_q     <= cycle_d;
         remaining_q <= remaining_d;
         rst_cnt_q   <= rst_cnt_d;
         cmd_err_q   <= cmd_err_d;
         mask_q      <= (state_q == S_RESETTING);
      end
   end

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: stimulus queues expected state transitions and cmd_err pulses, a negedge monitor checks them.
module tb_run_controller;
   import run_controller_pkg::*;

   localparam logic [2:0] ST_RST = 3'd0, ST_HALT = 3'd1, ST_RUN = 3'd2, ST_STEP = 3'd3, ST_FAULT = 3'd4;
   localparam logic [2:0] RS_NONE = 3'd0, RS_USER = 3'd1, RS_EBREAK = 3'd2, RS_STEP_DONE = 3'd3,
                          RS_ERROR = 3'd4, RS_TIMEOUT = 3'd5;
   localparam logic [1:0] OP_RUN = 2'd0, OP_HALT = 2'd1, OP_STEP = 2'd2, OP_RESTART = 2'd3;

   typedef struct packed {
      logic [2:0]  st;
      logic [2:0]  rsn;
      logic [31:0] cnt;
      logic [15:0] span;
   } trans_t;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i;
   logic [15:0] step_count_i;
   logic        cmd_err_o;
   logic        cpu_stop_i;
   cpu_error_t  cpu_error_i;
   logic        cpu_reset_o;
   logic        cpu_clk_en_o;
   logic [2:0]  state_o;
   logic [2:0]  halt_reason_o;
   logic [31:0] cycle_count_o;

   int          vectors = 0;
   int          miscompares = 0;
   trans_t      exp_q[$];
   logic [2:0]  err_q[$];
   logic [2:0]  prev_st = 3'd0;
   int          span_cnt = 0;

   run_controller #(
      .CYCLE_W(32), .RESET_CYCLES(2), .AUTO_RUN(0), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .step_count_i(step_count_i), .cmd_err_o(cmd_err_o),
      .cpu_stop_i(cpu_stop_i), .cpu_error_i(cpu_error_i),
      .cpu_reset_o(cpu_reset_o), .cpu_clk_en_o(cpu_clk_en_o),
      .state_o(state_o), .halt_reason_o(halt_reason_o), .cycle_count_o(cycle_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] n);
      cmd_valid_i  = 1'b1;
      cmd_op_i     = op;
      step_count_i = n;
      @(posedge clk_i);
      #1;
      cmd_valid_i  = 1'b0;
   endtask

   task automatic exp_tr(input logic [2:0] st, input logic [2:0] rsn, input logic [31:0] cnt, input logic [15:0] span);
      trans_t t;
      t = '{st: st, rsn: rsn, cnt: cnt, span: span};
      exp_q.push_back(t);
   endtask

   // span = cycles with cpu_reset high after release (RESETTING) or enabled ticks (other states) in the state just left
   always @(negedge clk_i) begin
      trans_t act, exp_rec;
      logic [40:0] rst_act, rst_exp;
      if (state_o !== prev_st) begin
         act = '{st: state_o, rsn: halt_reason_o, cnt: cycle_count_o, span: span_cnt[15:0]};
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL transition_unexpected got st=%0d rsn=%0d cnt=%0d span=%0d, none expected",
                     act.st, act.rsn, act.cnt, act.span);
         end else begin
            exp_rec = exp_q.pop_front();
            if (act !== exp_rec) begin
               miscompares++;
               $display("FAIL transition got st=%0d rsn=%0d cnt=%0d span=%0d, want st=%0d rsn=%0d cnt=%0d span=%0d",
                        act.st, act.rsn, act.cnt, act.span, exp_rec.st, exp_rec.rsn, exp_rec.cnt, exp_rec.span);
            end
         end
         span_cnt = 0;
         prev_st  = state_o;
      end
      if (reset_i) begin
         rst_act = {state_o, cpu_reset_o, halt_reason_o, cycle_count_o, cmd_err_o, cmd_ready_o, cpu_clk_en_o};
         rst_exp = {ST_RST, 1'b1, RS_NONE, 32'd0, 1'b0, 1'b0, 1'b1};
         vectors++;
         if (rst_act !== rst_exp) begin
            miscompares++;
            $display("FAIL reset_values got %h want %h", rst_act, rst_exp);
         end
      end
      if (cmd_err_o === 1'b1) begin
         vectors++;
         if (err_q.size() == 0) begin
            miscompares++;
            $display("FAIL cmd_err_unexpected got pulse in st=%0d, none expected", state_o);
         end else begin
            logic [2:0] est;
            est = err_q.pop_front();
            if (state_o !== est) begin
               miscompares++;
               $display("FAIL cmd_err_state got st=%0d want st=%0d", state_o, est);
            end
         end
      end
      if (state_o == ST_RST) span_cnt += (reset_i === 1'b0) ? 1 : 0;
      else                   span_cnt += (cpu_clk_en_o === 1'b1) ? 1 : 0;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish, want finish before 200000");
      $fatal(1);
   end

   initial begin
      reset_i      = 1'b1;
      cmd_valid_i  = 1'b0;
      cmd_op_i     = OP_RUN;
      step_count_i = 16'd0;
      cpu_stop_i   = 1'b0;
      cpu_error_i  = 2'b11;

      // reset sequence with errors present
      exp_tr(ST_HALT, RS_NONE, 0, 2);
      cyc(3);
      reset_i = 1'b0;
      cyc(3);
      cpu_error_i = '0;

      // HALT while halted is a no-op
      issue(OP_HALT, 16'd0);
      cyc(2);

      // STEP 5 then STEP 0
      exp_tr(ST_STEP, RS_NONE, 0, 0);
      exp_tr(ST_HALT, RS_STEP_DONE, 5, 5);
      issue(OP_STEP, 16'd5);
      cyc(8);
      exp_tr(ST_STEP, RS_NONE, 5, 0);
      exp_tr(ST_HALT, RS_STEP_DONE, 6, 1);
      issue(OP_STEP, 16'd0);
      cyc(4);

      // EBREAK on the 7th tick
      exp_tr(ST_RUN, RS_NONE, 6, 0);
      exp_tr(ST_HALT, RS_EBREAK, 12, 6);
      issue(OP_RUN, 16'd0);
      cyc(6);
      cpu_stop_i = 1'b1;
      cyc(1);
      cpu_stop_i = 1'b0;
      cyc(2);

      // illegal RUN while running, then user halt
      exp_tr(ST_RUN, RS_NONE, 12, 0);
      issue(OP_RUN, 16'd0);
      cyc(2);
      err_q.push_back(ST_RUN);
      issue(OP_RUN, 16'd0);
      cyc(2);
      exp_tr(ST_HALT, RS_USER, 18, 6);
      issue(OP_HALT, 16'd0);
      cyc(2);

      // error beats stop, RUN illegal in FAULT, RESTART recovers
      exp_tr(ST_RUN, RS_NONE, 18, 0);
      issue(OP_RUN, 16'd0);
      cyc(3);
      exp_tr(ST_FAULT, RS_ERROR, 21, 3);
      cpu_error_i = 2'b01;
      cpu_stop_i  = 1'b1;
      cyc(1);
      cpu_error_i = '0;
      cpu_stop_i  = 1'b0;
      cyc(1);
      err_q.push_back(ST_FAULT);
      issue(OP_RUN, 16'd0);
      cyc(2);
      exp_tr(ST_RST, RS_ERROR, 21, 0);
      exp_tr(ST_HALT, RS_NONE, 0, 2);
      issue(OP_RESTART, 16'd0);
      cyc(4);

      // RESTART beats a simultaneous cpu_stop
      exp_tr(ST_RUN, RS_NONE, 0, 0);
      issue(OP_RUN, 16'd0);
      cyc(2);
      exp_tr(ST_RST, RS_NONE, 2, 2);
      exp_tr(ST_HALT, RS_NONE, 0, 2);
      cpu_stop_i = 1'b1;
      issue(OP_RESTART, 16'd0);
      cpu_stop_i = 1'b0;
      cyc(4);

      // async reset mid-run, command during reset dropped
      exp_tr(ST_RUN, RS_NONE, 0, 0);
      issue(OP_RUN, 16'd0);
      cyc(3);
      exp_tr(ST_RST, RS_NONE, 0, 3);
      exp_tr(ST_HALT, RS_NONE, 0, 2);
      reset_i     = 1'b1;
      cmd_valid_i = 1'b1;
      cmd_op_i    = OP_RUN;
      cyc(2);
      reset_i     = 1'b0;
      cmd_valid_i = 1'b0;
      cyc(4);

`ifdef RUN_TIMEOUT_EN
      exp_tr(ST_RUN, RS_NONE, 0, 0);
      exp_tr(ST_FAULT, RS_TIMEOUT, 20, 20);
      issue(OP_RUN, 16'd0);
      cyc(25);
      exp_tr(ST_RST, RS_TIMEOUT, 20, 0);
      exp_tr(ST_HALT, RS_NONE, 0, 2);
      issue(OP_RESTART, 16'd0);
      cyc(4);
`else
      exp_tr(ST_RUN, RS_NONE, 0, 0);
      issue(OP_RUN, 16'd0);
      cyc(24);
      exp_tr(ST_HALT, RS_USER, 25, 25);
      issue(OP_HALT, 16'd0);
      cyc(2);
`endif

      for (int i = 0; i < 50 && (exp_q.size() != 0 || err_q.size() != 0); i++) cyc(1);
      vectors++;
      if (exp_q.size() != 0 || err_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d transitions and %0d cmd_err pending, want 0 and 0",
                  exp_q.size(), err_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
